// File: rtl/sweep_tracker.sv
// sweep_tracker: receive-side monitor for a one-hot bouncing sweep mask.
// Recovers lit position and direction, counts round trips and flags protocol errors.
module sweep_tracker #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned CNT_W   = 8,
   localparam int unsigned BIT_PTR = $clog2(WIDTH)
) (
   input  logic               clk_i,
   input  logic               arstn_i,
   input  logic               en_i,
   input  logic               clr_i,
   input  logic [WIDTH-1:0]   mask_i,
   output logic [BIT_PTR-1:0] pos_o,
   output logic               dir_o,
   output logic               valid_o,
   output logic               step_o,
   output logic               err_o,
   output logic [CNT_W-1:0]   sweep_cnt_o
);

   localparam int unsigned POP_W = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] TRACK = 2'd1;
   localparam logic [1:0] ERR   = 2'd2;

   localparam logic [BIT_PTR-1:0] LAST = BIT_PTR'(WIDTH - 1);
   localparam logic [BIT_PTR-1:0] ZERO = '0;
   localparam logic [BIT_PTR-1:0] ONE  = BIT_PTR'(1);

   logic [1:0]         state, state_next;
   logic [BIT_PTR-1:0] pos, pos_next;
   logic               dir, dir_next;
   logic               step, step_next;
   logic               err, err_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic [WIDTH-1:0]   prev_mask;

   logic [BIT_PTR-1:0] idx;
   logic [POP_W-1:0]   pop;
   logic               one_hot;
   logic               up_ok, turn_dn, dn_ok, turn_up, legal;

   // Priority-free decode: OR together indices of all set bits, qualified by popcount.
   always_comb begin
      idx = '0;
      pop = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (mask_i[i]) begin
            idx = idx | BIT_PTR'(i);
            pop = pop + POP_W'(1);
         end
      end
      one_hot = (pop == POP_W'(1));
   end

   // Classify the observed index against the four legal sweep moves.
   always_comb begin
      up_ok   = !dir && (pos != LAST) && (idx == pos + ONE);
      turn_dn = !dir && (pos == LAST) && (idx == LAST - ONE);
      dn_ok   =  dir && (pos != ZERO) && (idx == pos - ONE);
      turn_up =  dir && (pos == ZERO) && (idx == ONE);
      legal   = one_hot && (up_ok || turn_dn || dn_ok || turn_up);
   end

   // Next-state: FSM, position/direction, step pulse, sticky error and round-trip count.
   always_comb begin
      logic err_event;
      logic cnt_inc;
      state_next = state;
      pos_next   = pos;
      dir_next   = dir;
      step_next  = 1'b0;
      err_event  = 1'b0;
      cnt_inc    = 1'b0;
      unique case (state)
         IDLE: begin
            if (mask_i == WIDTH'(1)) begin
               state_next = TRACK;
               pos_next   = '0;
               dir_next   = 1'b0;
            end else if (mask_i != '0) begin
               state_next = ERR;
               err_event  = 1'b1;
            end
         end
         TRACK: begin
            if (mask_i == prev_mask) begin
               state_next = TRACK;
            end else if (mask_i == '0) begin
               // Generator disabled: not an error.
               state_next = IDLE;
            end else if (legal) begin
               pos_next  = idx;
               dir_next  = dir ^ (turn_dn | turn_up);
               step_next = 1'b1;
               cnt_inc   = (idx == ZERO);
            end else begin
               state_next = ERR;
               err_event  = 1'b1;
            end
         end
         ERR: begin
            if (mask_i == '0) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Clear first so a same-cycle event wins.
      err_next = clr_i ? 1'b0 : err;
      cnt_next = clr_i ? '0 : cnt;
      if (err_event) begin
         err_next = 1'b1;
      end
      if (cnt_inc) begin
         cnt_next = cnt_next + CNT_W'(1);
      end
   end

   // State registers: async reset, en_i low acts as a synchronous reset.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state     <= IDLE;
         pos       <= '0;
         dir       <= 1'b0;
         step      <= 1'b0;
         err       <= 1'b0;
         cnt       <= '0;
         prev_mask <= '0;
      end else if (!en_i) begin
         state     <= IDLE;
         pos       <= '0;
         dir       <= 1'b0;
         step      <= 1'b0;
         err       <= 1'b0;
         cnt       <= '0;
         prev_mask <= '0;
      end else begin
         state     <= state_next;
         pos       <= pos_next;
         dir       <= dir_next;
         step      <= step_next;
         err       <= err_next;
         cnt       <= cnt_next;
         prev_mask <= mask_i;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      valid_o     = (state == TRACK);
      pos_o       = pos;
      dir_o       = dir;
      step_o      = step;
      err_o       = err;
      sweep_cnt_o = cnt;
   end

endmodule

// File: tb/tb_sweep_tracker.sv
// tb_sweep_tracker: three tracker instances (W4/C8, W4/C2, W2/C2) checked against
// a bouncing-sweep reference model under directed and random stimulus.
module tb_sweep_tracker;

   logic       clk = 1'b0;
   logic       arstn = 1'b0;
   logic       en = 1'b1;
   logic       clr = 1'b0;
   logic [3:0] mask4 = '0;
   logic [1:0] mask2 = '0;

   logic [1:0] a_pos;  logic a_dir, a_valid, a_step, a_err;  logic [7:0] a_cnt;
   logic [1:0] b_pos;  logic b_dir, b_valid, b_step, b_err;  logic [1:0] b_cnt;
   logic [0:0] c_pos;  logic c_dir, c_valid, c_step, c_err;  logic [1:0] c_cnt;

   sweep_tracker #(.WIDTH(4), .CNT_W(8)) u_a (
      .clk_i(clk), .arstn_i(arstn), .en_i(en), .clr_i(clr), .mask_i(mask4),
      .pos_o(a_pos), .dir_o(a_dir), .valid_o(a_valid), .step_o(a_step),
      .err_o(a_err), .sweep_cnt_o(a_cnt));

   sweep_tracker #(.WIDTH(4), .CNT_W(2)) u_b (
      .clk_i(clk), .arstn_i(arstn), .en_i(en), .clr_i(clr), .mask_i(mask4),
      .pos_o(b_pos), .dir_o(b_dir), .valid_o(b_valid), .step_o(b_step),
      .err_o(b_err), .sweep_cnt_o(b_cnt));

   sweep_tracker #(.WIDTH(2), .CNT_W(2)) u_c (
      .clk_i(clk), .arstn_i(arstn), .en_i(en), .clr_i(clr), .mask_i(mask2),
      .pos_o(c_pos), .dir_o(c_dir), .valid_o(c_valid), .step_o(c_step),
      .err_o(c_err), .sweep_cnt_o(c_cnt));

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: mode 0 = idle, 1 = locked, 2 = error-hold.
   int m_mode[3], m_pos[3], m_dir[3], m_err[3], m_cnt[3], m_step[3], m_prev[3];
   int w_of[3]  = '{4, 4, 2};
   int cw_of[3] = '{8, 2, 2};

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Where a bouncing sweep must go next from (pos, dir).
   function automatic int bounce(input int w, input int p, input int d);
      if (d == 0) return (p == w - 1) ? w - 2 : p + 1;
      return (p == 0) ? 1 : p - 1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_mode[k] = 0; m_pos[k] = 0; m_dir[k] = 0; m_err[k] = 0;
         m_cnt[k] = 0; m_step[k] = 0; m_prev[k] = 0;
      end
   endtask

   task automatic model_step(input int k, input int m);
      int n, nx, ev, inc;
      ev = 0; inc = 0;
      m_step[k] = 0;
      if (!en) begin
         m_mode[k] = 0; m_pos[k] = 0; m_dir[k] = 0; m_err[k] = 0;
         m_cnt[k] = 0; m_prev[k] = 0;
         return;
      end
      case (m_mode[k])
         0: begin
            if (m == 1) begin
               m_mode[k] = 1; m_pos[k] = 0; m_dir[k] = 0;
            end else if (m != 0) begin
               m_mode[k] = 2; ev = 1;
            end
         end
         1: begin
            if (m == m_prev[k]) begin
               m_mode[k] = 1;
            end else if (m == 0) begin
               m_mode[k] = 0;
            end else if ($countones(m) != 1) begin
               m_mode[k] = 2; ev = 1;
            end else begin
               n  = $clog2(m);
               nx = bounce(w_of[k], m_pos[k], m_dir[k]);
               if (n == nx) begin
                  m_dir[k]  = (nx < m_pos[k]) ? 1 : 0;
                  m_pos[k]  = n;
                  m_step[k] = 1;
                  inc       = (n == 0) ? 1 : 0;
               end else begin
                  m_mode[k] = 2; ev = 1;
               end
            end
         end
         default: if (m == 0) m_mode[k] = 0;
      endcase
      if (clr) begin m_err[k] = 0; m_cnt[k] = 0; end
      if (ev != 0) m_err[k] = 1;
      if (inc != 0) m_cnt[k] = (m_cnt[k] + 1) % (1 << cw_of[k]);
      m_prev[k] = m;
   endtask

   task automatic check_one(input string nm, input int k, input int valid, input int pos,
                            input int dir, input int step, input int err, input int cnt);
      chk({nm, ".valid"}, valid, (m_mode[k] == 1) ? 1 : 0);
      chk({nm, ".step"}, step, m_step[k]);
      chk({nm, ".err"}, err, m_err[k]);
      chk({nm, ".cnt"}, cnt, m_cnt[k]);
      if (m_mode[k] == 1) begin
         chk({nm, ".pos"}, pos, m_pos[k]);
         chk({nm, ".dir"}, dir, m_dir[k]);
      end
   endtask

   task automatic check_all();
      check_one("a", 0, 32'(a_valid), 32'(a_pos), 32'(a_dir), 32'(a_step), 32'(a_err),
                32'(a_cnt));
      check_one("b", 1, 32'(b_valid), 32'(b_pos), 32'(b_dir), 32'(b_step), 32'(b_err),
                32'(b_cnt));
      check_one("c", 2, 32'(c_valid), 32'(c_pos), 32'(c_dir), 32'(c_step), 32'(c_err),
                32'(c_cnt));
   endtask

   // One clock: model consumes the inputs seen at the edge, outputs sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      model_step(0, int'(mask4));
      model_step(1, int'(mask4));
      model_step(2, int'(mask2));
      #1;
      check_all();
   endtask

   task automatic put4(input logic [3:0] v, input int n);
      mask4 = v;
      for (int i = 0; i < n; i++) tick();
   endtask

   // One round trip from pos 0 back to pos 0; clr optionally on the arrival cycle.
   task automatic trip(input logic with_clr);
      logic [3:0] seq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
      for (int i = 0; i < 5; i++) put4(seq[i], 1);
      clr = with_clr;
      put4(4'b0001, 1);
      clr = 1'b0;
   endtask

   function automatic int legal_next(input int k);
      if (m_mode[k] == 1) return 1 << bounce(w_of[k], m_pos[k], m_dir[k]);
      if (m_mode[k] == 0) return 1;
      return 0;
   endfunction

   initial begin
      int steps;
      int r;
      logic [3:0] sweep [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

      model_reset();
      #12;
      check_all();
      @(negedge clk);
      arstn = 1'b1;
      put4(4'b0000, 2);

      // First lock.
      put4(4'b0001, 1);
      chk("lock.valid", 32'(a_valid), 1);
      chk("lock.pos", 32'(a_pos), 0);
      chk("lock.step", 32'(a_step), 0);

      // Full sweep, each mask held 3 cycles.
      steps = 0;
      for (int i = 0; i < 7; i++) begin
         mask4 = sweep[i];
         for (int j = 0; j < 3; j++) begin
            tick();
            steps += int'(a_step);
         end
      end
      chk("sweep.steps", steps, 6);
      chk("sweep.cnt", 32'(a_cnt), 1);
      put4(4'b0010, 1);
      chk("turn.dir", 32'(a_dir), 0);
      chk("turn.pos", 32'(a_pos), 1);

      // Jump error, then idle, then clear.
      put4(4'b0000, 1);
      put4(4'b0001, 1);
      put4(4'b0100, 1);
      chk("jump.err", 32'(a_err), 1);
      chk("jump.valid", 32'(a_valid), 0);
      put4(4'b0000, 1);
      chk("idle.err", 32'(a_err), 1);
      clr = 1'b1;
      put4(4'b0000, 1);
      clr = 1'b0;
      chk("clr.err", 32'(a_err), 0);

      // Two-hot in lock; bad entry from idle.
      put4(4'b0001, 1);
      put4(4'b0011, 1);
      chk("twohot.err", 32'(a_err), 1);
      put4(4'b0000, 2);
      clr = 1'b1;
      put4(4'b0000, 1);
      clr = 1'b0;
      put4(4'b0100, 1);
      chk("badentry.err", 32'(a_err), 1);
      chk("badentry.valid", 32'(a_valid), 0);
      put4(4'b0000, 1);

      // Restart counts, three trips, then generator disable mid-sweep.
      en = 1'b0;
      put4(4'b0000, 1);
      en = 1'b1;
      put4(4'b0001, 1);
      for (int i = 0; i < 3; i++) trip(1'b0);
      put4(4'b0010, 1);
      put4(4'b0100, 1);
      put4(4'b0000, 1);
      chk("disable.valid", 32'(a_valid), 0);
      chk("disable.cnt", 32'(a_cnt), 3);
      en = 1'b0;
      put4(4'b0000, 1);
      en = 1'b1;
      chk("en_off.cnt", 32'(a_cnt), 0);
      chk("en_off.err", 32'(a_err), 0);

      // Counter wrap on the 2-bit instance, then clear colliding with increment.
      put4(4'b0001, 1);
      for (int i = 0; i < 4; i++) trip(1'b0);
      chk("wrap.b_cnt", 32'(b_cnt), 0);
      chk("wrap.a_cnt", 32'(a_cnt), 4);
      trip(1'b1);
      chk("clrhit.b_cnt", 32'(b_cnt), 1);
      chk("clrhit.a_cnt", 32'(a_cnt), 1);

      // Asynchronous reset away from the clock edge.
      #2 arstn = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      arstn = 1'b1;
      mask4 = '0;

      // WIDTH=2: 0,1,0,1,0 gives two round trips.
      mask2 = 2'b01; tick();
      for (int i = 0; i < 4; i++) begin
         mask2 = (i % 2 == 0) ? 2'b10 : 2'b01;
         tick();
      end
      chk("w2.cnt", 32'(c_cnt), 2);

      // Random phase: mostly legal sweeps with holds, disables, garbage, clears, en drops.
      for (int it = 0; it < 3000; it++) begin
         r = int'($urandom_range(0, 99));
         if (r < 70)      mask4 = 4'(legal_next(0));
         else if (r < 82) mask4 = mask4;
         else if (r < 88) mask4 = '0;
         else             mask4 = 4'($urandom_range(0, 15));
         r = int'($urandom_range(0, 99));
         if (r < 70)      mask2 = 2'(legal_next(2));
         else if (r < 82) mask2 = mask2;
         else if (r < 88) mask2 = '0;
         else             mask2 = 2'($urandom_range(0, 3));
         clr = ($urandom_range(0, 29) == 0);
         en  = ($urandom_range(0, 99) != 0);
         tick();
      end
      clr = 1'b0;
      en  = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sweep_tracker.md
Name: sweep_tracker

Overview:
Receive-side monitor for the one-hot sweep mask produced by the sweep generator.
It samples the mask each clock and recovers the lit position and the sweep direction. It also counts completed round trips and flags any step that breaks the sweep protocol.
It sits beside the generator in the pulse-generator datapath and serves as a self-check and status source for the LED/pulse front end.

Parameters:
WIDTH, 4, mask width; legal range WIDTH >= 2
CNT_W, 8, width of the round-trip counter
BIT_PTR, $clog2(WIDTH), localparam; width of the position index

Ports:
clk_i  input  1  clock; all logic on the rising edge
arstn_i  input  1  reset; asynchronous, active-low
en_i  input  1  block enable; low = synchronous return to reset values
clr_i  input  1  single-cycle pulse; clears err_o and sweep_cnt_o
mask_i  input  WIDTH  sweep mask under observation; synchronous to clk_i
pos_o  output  BIT_PTR  index of the lit bit; valid only when valid_o=1
dir_o  output  1  0 = ascending (toward MSB), 1 = descending
valid_o  output  1  tracker locked, pos_o/dir_o meaningful
step_o  output  1  one-cycle pulse per accepted legal step
err_o  output  1  sticky protocol-error flag
sweep_cnt_o  output  CNT_W  completed round trips, modulo 2^CNT_W

Behaviour:
- Reset (arstn_i=0) or en_i=0: all outputs 0, FSM in IDLE, stored previous mask 0. en_i=0 also clears err_o and sweep_cnt_o.
- Registered outputs: a change on mask_i at edge N is reflected on the outputs after edge N+1 (1-cycle latency).
- FSM states:
  - IDLE: valid_o=0.
  - TRACK: valid_o=1.
  - ERR: valid_o=0.
- IDLE transitions:
  - mask_i all-zero: stay in IDLE.
  - mask_i == 1 (bit 0 only): go to TRACK with pos=0, dir=0. No step_o pulse.
  - Any other non-zero value: go to ERR and set err_o.
- TRACK, mask_i unchanged: hold state; no step_o pulse.
- TRACK, mask_i all-zero: return to IDLE. This is a generator disable, not an error. err_o and sweep_cnt_o are kept.
- TRACK, mask_i not one-hot (two or more bits set): go to ERR and set err_o.
- TRACK, mask_i one-hot at new index n. Legal steps:
  - dir=0 and n=pos+1, with pos<WIDTH-1.
  - dir=0, pos=WIDTH-1, n=WIDTH-2: dir becomes 1.
  - dir=1 and n=pos-1, with pos>0.
  - dir=1, pos=0, n=1: dir becomes 0.
- TRACK, any legal step: pos<=n and step_o pulses for 1 cycle.
- TRACK, any other index (jump, or wrong direction): go to ERR and set err_o.
- Round trip: a legal descending step that lands on pos=0 increments sweep_cnt_o, which wraps from 2^CNT_W-1 to 0.
- WIDTH=2: sequence is 0,1,0,1. The step 0→1 sets dir=0, the step 1→0 sets dir=1, and every arrival at 0 counts as a round trip.
- ERR: stays in ERR until mask_i is all-zero for 1 cycle, then goes to IDLE. err_o stays set after leaving ERR.
- clr_i: clears err_o and sweep_cnt_o to 0 at the next edge.
  - If an error event or a count increment occurs in the same cycle, the event wins: err_o=1, or sweep_cnt_o=1 respectively.
  - clr_i does not change FSM state.
- Position and direction are computed from mask_i by priority-free one-hot decode, validated by a popcount==1 check.

Test Plan:
- WIDTH=4. Reset, then mask_i=0001 → one cycle later valid_o=1, pos_o=0, dir_o=0, step_o=0, err_o=0.
- Masks 0001,0010,0100,1000,0100,0010,0001, each held 3 cycles.
  - pos_o must be 0,1,2,3,2,1,0; step_o must give 6 single-cycle pulses.
  - dir_o must be 1 from the 3→2 step onward.
  - sweep_cnt_o 0→1 on arrival at pos 0.
  - Then 0010 → dir_o=0, pos_o=1.
- In TRACK at pos 0, mask_i=0100 → err_o=1, valid_o=0. Then mask_i=0000 → IDLE with err_o still 1. Then clr_i pulse → err_o=0.
- In TRACK, mask_i=0011 → err_o=1. From IDLE, mask_i=0100 → err_o=1, valid_o=0.
- Mid-sweep, with sweep_cnt_o=3:
  - mask_i=0000 → valid_o=0, sweep_cnt_o stays 3.
  - en_i=0 for 1 cycle → sweep_cnt_o=0, all outputs 0.
- CNT_W=2, run 4 full round trips → sweep_cnt_o steps 1,2,3,0. clr_i asserted on the same cycle as an increment → sweep_cnt_o=1.
